// File: rtl/serial_logic_32.sv
// Bit-serial bitwise logic unit: one result bit per clock, LSB first, behind a
// start/busy/done handshake. States: IDLE (waiting), RUN (shifting), DONE (one-cycle result strobe).
module serial_logic_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [1:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             zero_q, zero_d;

  logic             accept;
  logic             last_bit;
  logic             nbit;
  logic [WIDTH-1:0] acc_shift;

  // start is only honoured when no operation is in flight
  assign accept   = start && (state_q != S_RUN);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      op_q    <= 2'b00;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (op_q)
      2'b00:   nbit = a_sh_q[0] & b_sh_q[0];
      2'b01:   nbit = a_sh_q[0] | b_sh_q[0];
      2'b10:   nbit = a_sh_q[0] ^ b_sh_q[0];
      default: nbit = ~(a_sh_q[0] | b_sh_q[0]);
    endcase
  end

  assign acc_shift = {nbit, acc_q[WIDTH-1:1]};

  always_comb begin
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    acc_d  = acc_q;
    res_d  = res_q;
    op_d   = op_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    zero_d = zero_q;
    if (accept) begin
      a_sh_d = a;
      b_sh_d = b;
      op_d   = op;
      acc_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (state_q == S_RUN) begin
      acc_d  = acc_shift;
      a_sh_d = a_sh_q >> 1;
      b_sh_d = b_sh_q >> 1;
      cnt_d  = cnt_q + 1'b1;
      // res and zero update together so zero is valid alongside done
      if (last_bit) begin
        res_d  = acc_shift;
        zero_d = (acc_shift == '0);
        done_d = 1'b1;
        busy_d = 1'b0;
      end
    end
  end

  assign res  = res_q;
  assign busy = busy_q;
  assign done = done_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_serial_logic_32.sv
// Directed and random self-checking bench for serial_logic_32.
module tb_serial_logic_32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] res;
  logic        busy;
  logic        done;
  logic        zero;

  int n_checks;
  int n_errors;
  int done_cnt;

  serial_logic_32 #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .res   (res),
    .busy  (busy),
    .done  (done),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  initial begin
    #2000000;
    $display("FAIL timeout: got still running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  // called 1 time unit after an edge; start is taken on the following edge
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done(input string tag, input int exp_cycles, input logic [31:0] exp_res);
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_cycles"}, n, exp_cycles);
    check({tag, "_res"}, res, exp_res);
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, (exp_res == 32'd0)});
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int d0;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    n_checks = 0;
    n_errors = 0;
    done_cnt = 0;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_res", res, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    launch(2'b00, 32'h0000_0039, 32'h0000_0003);
    wait_done("and1", 32, 32'h0000_0001);
    @(posedge clk);
    #1;
    check("and1_done_drop", {31'd0, done}, 32'd0);
    launch(2'b00, 32'h0000_0002, 32'h0000_0001);
    wait_done("and2", 32, 32'h0000_0000);
    @(posedge clk);
    #1;

    launch(2'b01, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
    wait_done("or", 32, 32'hFFFF_FFFF);
    launch(2'b10, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    check("b2b_done_drop", {31'd0, done}, 32'd0);
    check("b2b_res_held", res, 32'hFFFF_FFFF);
    wait_done("xor", 32, 32'h0000_0000);
    @(posedge clk);
    #1;

    d0 = done_cnt;
    launch(2'b11, 32'h0, 32'h0);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1;
    a     = 32'hFFFF_FFFF;
    op    = 2'b00;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ign_busy", {31'd0, busy}, 32'd1);
    wait_done("nor", 26, 32'hFFFF_FFFF);
    repeat (2) @(posedge clk);
    #1;
    check("nor_one_done", done_cnt - d0, 32'd1);
    check("nor_res_hold", res, 32'hFFFF_FFFF);

    d0 = done_cnt;
    launch(2'b01, 32'h1234_5678, 32'h0);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_res", res, 32'h0);
    check("mid_rst_zero", {31'd0, zero}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("mid_rst_no_done", done_cnt - d0, 32'd0);
    launch(2'b00, 32'hFFFF_0000, 32'h0FF0_0FF0);
    wait_done("post_rst_and", 32, 32'h0FF0_0000);
    @(posedge clk);
    #1;

    d0 = done_cnt;
    for (int i = 0; i < 200; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      launch(ro, ra, rb);
      wait_done("rand", 32, model(ro, ra, rb));
    end
    @(posedge clk);
    #1;
    check("rand_done_count", done_cnt - d0, 32'd200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_logic_32.md
Name: serial_logic_32

Overview:
- Bit-serial 32-bit bitwise logic unit: the sequential, multi-cycle counterpart of the combinational and_32 datapath.
- Accepts two operands and an operation under a start/busy/done handshake, processes one bit per clock (LSB first) and presents a registered result.
- Used as a low-area logic slice for the multi-cycle datapath. Its result must match the combinational and_32 (and its OR/XOR/NOR siblings) bit for bit.

Parameters:
- WIDTH, 32, operand and result width in bits; counter width is clog2(WIDTH)+1.

Ports:
- clk  input  1  system clock, all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled on a rising edge only when busy=0
- op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOR
- a  input  WIDTH  operand A, captured on an accepted start
- b  input  WIDTH  operand B, captured on an accepted start
- res  output  WIDTH  registered result of the last completed operation
- busy  output  1  high while an operation is in progress
- done  output  1  single-cycle pulse when res has just been updated
- zero  output  1  high when res == 0

Behaviour:
- Single clock domain. rst_n is asynchronous and active-low; all outputs are registered.
- Reset, asserted at any time including mid-operation:
  - state=IDLE; res=0, busy=0, done=0, zero=1.
  - Internal shift registers, accumulator and counter cleared.
  - An in-flight operation is abandoned with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge captures a, b and op into internal registers, clears the accumulator, sets cnt=0 and moves to RUN; busy=1 from that edge.
  - start=0: remain in IDLE.
- RUN, each edge:
  - bit = f(op, a_sh[0], b_sh[0]).
  - The accumulator shifts right with the new bit entering at MSB.
  - a_sh and b_sh shift right; cnt increments.
  - On the edge where cnt reaches WIDTH-1: load res with the final accumulator value (including this bit), set done=1, busy=0, move to DONE.
- DONE, lasts one cycle:
  - done drops at the next edge.
  - If start=1 in this cycle it is accepted exactly as in IDLE, so back-to-back operations are allowed; otherwise go to IDLE.
- Latency: start accepted at edge E0 -> busy high E0..E(WIDTH-1), res/done updated at edge E(WIDTH). For WIDTH=32, done is high 32 cycles after start is sampled.
- start while busy=1 is ignored: no capture and no effect on the in-flight operation. a, b and op may change freely while busy.
- res holds its value between operations. Partial results are never visible on res.
- zero is registered together with res, so it is valid in the same cycle done rises.
- NOR is the bitwise complement of OR; no arithmetic and no carries. Result width equals WIDTH, with no extension.
- op is captured at start. A changed op during RUN has no effect.

Test Plan:
- Reset: rst_n=0 for 2 cycles -> res=0x00000000, busy=0, done=0, zero=1.
- AND: op=00, a=0x00000039, b=0x00000003, start 1 cycle -> busy high 32 cycles, then done pulse 1 cycle, res=0x00000001, zero=0. Then a=0x00000002, b=0x00000001 -> res=0x00000000, zero=1.
- OR, then XOR back-to-back:
  - OR: op=01, a=0xF0F0F0F0, b=0x0F0F0F0F -> res=0xFFFFFFFF.
  - Keep start=1 during the OR done cycle with op=10, a=b=0xDEADBEEF -> second operation accepted with no idle gap, res=0x00000000, zero=1.
- NOR plus ignored start: op=11, a=0, b=0 -> res=0xFFFFFFFF. During RUN, pulse start with a=0xFFFFFFFF and change op -> ignored, result still 0xFFFFFFFF, exactly one done pulse.
- Reset mid-operation: assert rst_n=0 at cycle 10 of RUN -> busy=0 and res=0 immediately (asynchronous), no done pulse. After release, a fresh AND of 0xFFFF0000 & 0x0FF00FF0 -> 0x0FF00000.
- Random self-check: 200 random a/b/op vectors compared against the combinational expression at each done pulse. Zero mismatches required, and done pulse count equals accepted starts.
